div256seq: RTL
==============

Name: div256seq

Overview:
- Sequential radix-2 restoring divider. It divides a 2W-bit dividend by a W-bit divisor and returns a W-bit quotient and a W-bit remainder.
- It is the inverse companion of the 128x128 Karatsuba multiplier. Its 256-bit product format is accepted directly as the dividend.
- Used for modular reduction and for checking product results in the arithmetic datapath.
- Multi-cycle, with a start/busy/done handshake. One quotient bit is produced per clock.

Parameters:
- W, 128: divisor, quotient and remainder width. The dividend is 2W bits.
- CW, 8: iteration counter width. Must satisfy 2^CW >= W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when busy=0.
- dividend  input  2W  numerator. Captured on an accepted start.
- divisor  input  W  denominator. Captured on an accepted start.
- busy  output  1  operation in progress. start is ignored while high.
- done  output  1  one-cycle pulse. Results are valid from this cycle.
- ovf  output  1  quotient overflow or divide-by-zero for the last operation.
- quotient  output  W  registered quotient.
- remainder  output  W  registered remainder.

Behaviour:
- Reset: synchronous and active-high. At the clk edge where reset=1:
  - busy, done, ovf, quotient and remainder all go to 0; state goes to IDLE.
  - Any in-flight operation is aborted with no done pulse.
  - Reset has priority over start.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: busy=1, one cycle. Used only for the ovf path.
- Accept: at edge k, if state=IDLE, start=1 and reset=0:
  - divisor is latched into D.
  - rem (W+1 bits) is loaded with dividend[2W-1:W].
  - Shift register S is loaded with dividend[W-1:0].
  - cnt is set to 0 and done is cleared.
  - ovf_cond = (divisor==0) or (dividend[2W-1:W] >= divisor).
  - If ovf_cond=1, next state is FIN; otherwise next state is RUN.
- RUN step, on each edge while in RUN:
  - t = {rem[W-1:0], S[W-1]}; S shifts left by 1.
  - If t >= D: rem = t - D and qbit = 1. Otherwise rem = t and qbit = 0.
  - qbit is shifted into the quotient LSB; cnt increments.
  - rem never exceeds W bits after subtraction, because of the pre-check.
- Completion: the step edge where cnt==W-1 (edge k+W) is the last step.
  - At that same edge: quotient and remainder outputs update, done=1, ovf=0, state goes to IDLE, busy=0.
  - Total latency is W clocks from the accepting edge: 128 for W=128.
- FIN, at edge k+1:
  - quotient = all ones, remainder = 0, ovf=1, done=1.
  - State goes to IDLE.
- done rules:
  - High for exactly one cycle, then cleared at the next edge.
  - Cleared at that edge even if a new start is accepted there.
- Output hold: quotient, remainder and ovf hold their values until the next completion or reset. They do not change during RUN.
- Back-to-back: start may be held high or asserted in the done cycle, since busy=0. It is accepted and the next operation begins immediately.
- Inputs: dividend and divisor may change freely after the accept edge.
- Width rule: the comparison and subtraction are done at W+1 bits. No truncation is allowed.

Test Plan:
- Simple case: start with dividend=100, divisor=7.
  - done exactly 128 cycles after the accept edge.
  - quotient=14, remainder=2, ovf=0.
  - busy high for the whole interval.
- Wide case: dividend=2^128, divisor=3.
  - quotient=0x5555_..._5555 (128 bits), remainder=1, ovf=0.
- Round trip with the multiplier: for random a, b (b≠0) and r<b, use dividend = a*b + r.
  - quotient=a, remainder=r.
  - Run 1000 vectors back-to-back, with start asserted in each done cycle.
- Overflow and divide-by-zero:
  - divisor=0 → done and ovf=1 one cycle after accept, quotient=all ones, remainder=0.
  - dividend high half=5, divisor=5 → same response.
  - A following normal op clears ovf.
- Handshake:
  - start pulsed during RUN with different operands → ignored; the result matches the first operands.
  - Exactly one done pulse per accepted start.
- Reset mid-op: assert reset at cycle 60 of RUN.
  - Next cycle: busy=0, done=0, ovf=0, quotient=0, remainder=0.
  - No done pulse for the aborted op.
  - A new start then completes correctly in 128 cycles.

Source files
------------

// File: rtl/div256seq.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// One quotient bit per clock; overflow and divide-by-zero take a one-cycle FIN path.
module div256seq #(
    parameter int W  = 128,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rmd_q, rmd_d;

    logic [W:0]    t;
    logic [W-1:0]  diff;
    logic          ge;
    logic          ovf_cond;

    // t needs W+1 bits; when t >= D the difference always fits back into W bits.
    always_comb begin
        t        = {rem_q, s_q[W-1]};
        ge       = (t >= {1'b0, d_q});
        diff     = t[W-1:0] - d_q;
        ovf_cond = (divisor == '0) || (dividend[2*W-1:W] >= divisor);

        state_d = state_q;
        rem_d   = rem_q;
        s_d     = s_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = divisor;
                    rem_d   = dividend[2*W-1:W];
                    s_d     = dividend[W-1:0];
                    cnt_d   = '0;
                    state_d = ovf_cond ? FIN : RUN;
                end
            end
            RUN: begin
                // S doubles as the quotient accumulator: dividend bits leave at the top, qbits enter at the bottom.
                rem_d = ge ? diff : t[W-1:0];
                s_d   = {s_q[W-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    quo_d   = {s_q[W-2:0], ge};
                    rmd_d   = ge ? diff : t[W-1:0];
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            FIN: begin
                quo_d   = '1;
                rmd_d   = '0;
                ovf_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        s_q   <= s_d;
        d_q   <= d_d;
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule
